// File: rtl/cache_line_responder.sv
// Line-to-word responder: splits each 128-bit line request into four
// 32-bit beats on a word bus and completes the line with a one-cycle ack.
module cache_line_responder #(
    parameter int SKIP_EMPTY_BEATS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  line_address,
    input  logic         line_read,
    input  logic         line_write,
    input  logic [127:0] line_writedata,
    input  logic [15:0]  line_byteenable,
    output logic         line_waitrequest,
    output logic [127:0] line_readdata,
    output logic [31:0]  word_address,
    output logic         word_read,
    output logic         word_write,
    output logic [31:0]  word_writedata,
    output logic [3:0]   word_byteenable,
    input  logic         word_waitrequest,
    input  logic [31:0]  word_readdata
);

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t       r_state;
    logic [31:0]  r_base;
    logic [127:0] r_wd;
    logic [15:0]  r_be;
    logic         r_wr;
    logic [1:0]   r_beat;

    logic         w_idle;
    logic [31:0]  w_base;
    logic [127:0] w_wd;
    logic [15:0]  w_be;
    logic         w_wr;
    logic [2:0]   w_from;
    logic         w_found;
    logic [1:0]   w_idx;
    logic [31:0]  w_addr;
    logic [31:0]  w_data;
    logic [3:0]   w_bev;

    // In IDLE the beat search runs on the live request so beat 0 issues next cycle
    assign w_idle = (r_state == IDLE);
    assign w_base = w_idle ? (line_address & 32'hFFFF_FFF0) : r_base;
    assign w_wd   = w_idle ? line_writedata : r_wd;
    assign w_be   = w_idle ? line_byteenable : r_be;
    assign w_wr   = w_idle ? line_write : r_wr;
    assign w_from = w_idle ? 3'd0 : ({1'b0, r_beat} + 3'd1);

    always_comb begin
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(w_from) &&
                (!w_wr || (SKIP_EMPTY_BEATS == 0) ||
                 (w_be[4*i +: 4] != 4'h0))) begin
                w_found = 1'b1;
                w_idx   = 2'(i);
            end
        end
    end

    assign w_addr = w_base + {28'h0, w_idx, 2'b00};
    assign w_data = w_wd[32*w_idx +: 32];
    assign w_bev  = w_wr ? w_be[4*w_idx +: 4] : 4'hf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            line_waitrequest <= 1'b1;
            word_read        <= 1'b0;
            word_write       <= 1'b0;
            r_beat           <= 2'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    line_waitrequest <= 1'b1;
                    if (line_read || line_write) begin
                        r_base <= w_base;
                        r_wd   <= line_writedata;
                        r_be   <= line_byteenable;
                        r_wr   <= line_write;
                        if (w_found) begin
                            r_state         <= BEAT;
                            r_beat          <= w_idx;
                            word_address    <= w_addr;
                            word_writedata  <= w_data;
                            word_byteenable <= w_bev;
                            word_read       <= !line_write;
                            word_write      <= line_write;
                        end else begin
                            r_state          <= DONE;
                            line_waitrequest <= 1'b0;
                        end
                    end
                end
                BEAT: begin
                    if (!word_waitrequest) begin
                        if (!r_wr)
                            line_readdata[32*r_beat +: 32] <= word_readdata;
                        if (w_found) begin
                            r_beat          <= w_idx;
                            word_address    <= w_addr;
                            word_writedata  <= w_data;
                            word_byteenable <= w_bev;
                        end else begin
                            word_read        <= 1'b0;
                            word_write       <= 1'b0;
                            r_state          <= DONE;
                            line_waitrequest <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    line_waitrequest <= 1'b1;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_responder.sv
// Scoreboard bench for cache_line_responder: expected beats and line
// completions are queued by the stimulus and checked by a monitor.
module tb_cache_line_responder;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    typedef struct {
        logic         rd;
        logic [127:0] data;
    } line_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  line_address;
    logic         line_read;
    logic         line_write;
    logic [127:0] line_writedata;
    logic [15:0]  line_byteenable;
    logic         line_waitrequest;
    logic [127:0] line_readdata;
    logic [31:0]  word_address;
    logic         word_read;
    logic         word_write;
    logic [31:0]  word_writedata;
    logic [3:0]   word_byteenable;
    logic         word_waitrequest;
    logic [31:0]  word_readdata;

    logic         z_line_write;
    logic         z_line_waitrequest;
    logic [127:0] z_line_readdata;
    logic [31:0]  z_word_address;
    logic         z_word_read;
    logic         z_word_write;
    logic [31:0]  z_word_writedata;
    logic [3:0]   z_word_byteenable;

    beat_t exp_beats[$];
    line_t exp_lines[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    hold_cnt = 0;
    int    stall_seen = 0;
    int    stall_len = 3;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a[31:4] == 28'h0000123) ? (32'hA0 + {30'h0, a[3:2]})
                                         : (a ^ 32'h5A5A_0000);
    endfunction

    assign word_readdata    = mem(word_address);
    assign word_waitrequest = word_read && (word_address == stall_addr)
                              && (stall_seen < stall_len);

    always @(posedge clk)
        if (word_waitrequest) stall_seen <= stall_seen + 1;

    cache_line_responder #(.SKIP_EMPTY_BEATS(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .line_address(line_address), .line_read(line_read),
        .line_write(line_write), .line_writedata(line_writedata),
        .line_byteenable(line_byteenable),
        .line_waitrequest(line_waitrequest),
        .line_readdata(line_readdata),
        .word_address(word_address), .word_read(word_read),
        .word_write(word_write), .word_writedata(word_writedata),
        .word_byteenable(word_byteenable),
        .word_waitrequest(word_waitrequest),
        .word_readdata(word_readdata)
    );

    cache_line_responder #(.SKIP_EMPTY_BEATS(0)) u_noskip (
        .clk(clk), .rst_n(rst_n),
        .line_address(32'h0000_4000), .line_read(1'b0),
        .line_write(z_line_write), .line_writedata(line_writedata),
        .line_byteenable(16'h0f00),
        .line_waitrequest(z_line_waitrequest),
        .line_readdata(z_line_readdata),
        .word_address(z_word_address), .word_read(z_word_read),
        .word_write(z_word_write), .word_writedata(z_word_writedata),
        .word_byteenable(z_word_byteenable),
        .word_waitrequest(1'b0),
        .word_readdata(32'h0)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pb(input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
        beat_t b;
        b.wr = wr; b.addr = a; b.data = d; b.be = be;
        exp_beats.push_back(b);
    endtask

    task automatic pl(input logic rd, input logic [127:0] d);
        line_t l;
        l.rd = rd; l.data = d;
        exp_lines.push_back(l);
    endtask

    task automatic monitor_cycle();
        beat_t b;
        line_t l;
        if (rst_n) begin
            if (word_read && word_address == stall_addr) hold_cnt++;
            if ((word_read || word_write) && !word_waitrequest) begin
                if (exp_beats.size() == 0) begin
                    chk("beat_unexpected", 128'(word_address), 128'hX);
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat_addr", 128'(word_address), 128'(b.addr));
                    chk("beat_wr", 128'(word_write), 128'(b.wr));
                    chk("beat_rd", 128'(word_read), 128'(!b.wr));
                    chk("beat_be", 128'(word_byteenable), 128'(b.be));
                    if (b.wr)
                        chk("beat_data", 128'(word_writedata), 128'(b.data));
                end
            end
            if (!line_waitrequest) begin
                if (exp_lines.size() == 0) begin
                    chk("line_unexpected", 128'(line_waitrequest), 128'd1);
                end else begin
                    l = exp_lines.pop_front();
                    if (l.rd) chk("line_rdata", line_readdata, l.data);
                end
            end
        end
    endtask

    task automatic do_line(input logic [31:0] a, input logic rd,
                           input logic wr, input logic [127:0] wd,
                           input logic [15:0] be, input int lat);
        int n;
        @(posedge clk); #1;
        line_address = a; line_read = rd; line_write = wr;
        line_writedata = wd; line_byteenable = be;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (line_waitrequest && n < 40);
        line_read = 1'b0;
        line_write = 1'b0;
        chk("latency", 128'(n), 128'(lat));
        @(posedge clk); #1;
        chk("ack_one_cycle", 128'(line_waitrequest), 128'd1);
    endtask

    initial begin
        int k;
        int h0;
        logic [3:0] zbe [4];
        zbe[0] = 4'h0; zbe[1] = 4'h0; zbe[2] = 4'hf; zbe[3] = 4'h0;
        rst_n = 1'b0;
        line_address = '0; line_read = 1'b0; line_write = 1'b0;
        line_writedata = '0; line_byteenable = '0;
        z_line_write = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitreq", 128'(line_waitrequest), 128'd1);
        chk("rst_word_read", 128'(word_read), 128'd0);
        chk("rst_word_write", 128'(word_write), 128'd0);
        @(negedge clk) rst_n = 1'b1;

        // plain read, zero waits
        for (int i = 0; i < 4; i++) pb(1'b0, 32'h1230 + 32'(4*i), 32'h0, 4'hf);
        pl(1'b1, 128'h000000A3_000000A2_000000A1_000000A0);
        do_line(32'h0000_1234, 1'b1, 1'b0, '0, '0, 5);

        // full write
        pb(1'b1, 32'h2000, 32'h11111111, 4'hf);
        pb(1'b1, 32'h2004, 32'h22222222, 4'hf);
        pb(1'b1, 32'h2008, 32'h33333333, 4'hf);
        pb(1'b1, 32'h200C, 32'h44444444, 4'hf);
        pl(1'b0, '0);
        do_line(32'h0000_2000, 1'b0, 1'b1,
                128'h44444444_33333333_22222222_11111111, 16'hffff, 5);

        // single non-empty beat; command with both set is a write
        pb(1'b1, 32'h2108, 32'h33333333, 4'hf);
        pl(1'b0, '0);
        do_line(32'h0000_2105, 1'b1, 1'b1,
                128'h44444444_33333333_22222222_11111111, 16'h0f00, 2);

        // empty write completes in cycle 1
        pl(1'b0, '0);
        do_line(32'h0000_2200, 1'b0, 1'b1, 128'h1, 16'h0000, 1);

        // sparse write: beats 0 and 3 only
        pb(1'b1, 32'h2300, 32'hAAAA0000, 4'h1);
        pb(1'b1, 32'h230C, 32'hDDDD0003, 4'h8);
        pl(1'b0, '0);
        do_line(32'h0000_2300, 1'b0, 1'b1,
                128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 16'h8001, 3);

        // read with beat 1 stalled 3 cycles
        stall_addr = 32'h0000_1234;
        h0 = hold_cnt;
        for (int i = 0; i < 4; i++) pb(1'b0, 32'h1230 + 32'(4*i), 32'h0, 4'hf);
        pl(1'b1, 128'h000000A3_000000A2_000000A1_000000A0);
        do_line(32'h0000_123C, 1'b1, 1'b0, '0, '0, 8);
        chk("stall_hold_cycles", 128'(hold_cnt - h0), 128'd4);
        stall_addr = 32'hFFFF_FFFF;

        // reset during beat 2 of a write
        pb(1'b1, 32'h3000, 32'h11111111, 4'hf);
        pb(1'b1, 32'h3004, 32'h22222222, 4'hf);
        @(posedge clk); #1;
        line_address = 32'h0000_3000; line_write = 1'b1;
        line_writedata = 128'h44444444_33333333_22222222_11111111;
        line_byteenable = 16'hffff;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!(word_write && word_address == 32'h3008) && k < 20);
        chk("rst_beat2_cycle", 128'(k), 128'd3);
        rst_n = 1'b0;
        line_write = 1'b0;
        #1;
        chk("rst_mid_write", 128'(word_write), 128'd0);
        chk("rst_mid_read", 128'(word_read), 128'd0);
        chk("rst_mid_waitreq", 128'(line_waitrequest), 128'd1);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4; i++) pb(1'b0, 32'h1230 + 32'(4*i), 32'h0, 4'hf);
        pl(1'b1, 128'h000000A3_000000A2_000000A1_000000A0);
        do_line(32'h0000_1230, 1'b1, 1'b0, '0, '0, 5);

        // no-skip instance issues all four beats
        @(posedge clk); #1;
        line_writedata = 128'h44444444_33333333_22222222_11111111;
        z_line_write = 1'b1;
        @(posedge clk); #1;
        z_line_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("noskip_write", 128'(z_word_write), 128'd1);
            chk("noskip_addr", 128'(z_word_address), 128'(32'h4000 + 32'(4*i)));
            chk("noskip_be", 128'(z_word_byteenable), 128'(zbe[i]));
            @(posedge clk); #1;
        end
        chk("noskip_done", 128'(z_line_waitrequest), 128'd0);
        chk("noskip_strobe_off", 128'(z_word_write), 128'd0);

        repeat (2) @(posedge clk);
        chk("beats_left", 128'(exp_beats.size()), 128'd0);
        chk("lines_left", 128'(exp_lines.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
